// File: rtl/delay_timer_bank_pkg.sv
// ----------------------------------------------------------------------------
// delay_timer_bank_pkg
//   Shared constants for the programmable delay timer bank.
//   - MODE_ONESHOT / MODE_PERIODIC : per-channel mode encodings (sampled at Start)
//   - ST_IDLE / ST_RUN             : channel FSM state encodings
//   - calc_ch_bits()               : channel-index width, never narrower than 1
// ----------------------------------------------------------------------------
package delay_timer_bank_pkg;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // A single-channel bank still needs a 1-bit LoadCh port.
    function automatic int calc_ch_bits(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/delay_timer_channel.sv
// ----------------------------------------------------------------------------
// delay_timer_channel
//   One programmable delay timer: shadow/active period registers, counter,
//   mode bit, IDLE/RUN FSM and registered Timeout/Busy outputs.
//
//   Ports
//     Clock     in   rising-edge clock
//     MR_n      in   synchronous active-low reset
//     Enable    in   global run; low freezes the counter while RUN
//     LoadWe    in   write LoadValue into the shadow period
//     LoadValue in   period value P
//     Start     in   start / restart request
//     Stop      in   abort request (wins over Start)
//     Mode      in   0 one-shot, 1 periodic; latched at Start
//     Timeout   out  one-cycle pulse when the counter reaches the period
//     Busy      out  channel is running
//     Count     out  current counter value
// ----------------------------------------------------------------------------
module delay_timer_channel
    import delay_timer_bank_pkg::*;
#(
    parameter int          WIDTH          = 27,
    parameter int unsigned DEFAULT_PERIOD = 3
) (
    input  logic             Clock,
    input  logic             MR_n,
    input  logic             Enable,
    input  logic             LoadWe,
    input  logic [WIDTH-1:0] LoadValue,
    input  logic             Start,
    input  logic             Stop,
    input  logic             Mode,
    output logic             Timeout,
    output logic             Busy,
    output logic [WIDTH-1:0] Count
);

    localparam logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(DEFAULT_PERIOD);

    logic [0:0]       state_reg,   state_next;
    logic [WIDTH-1:0] counter_reg, counter_next;
    logic [WIDTH-1:0] shadow_reg,  shadow_next;
    logic [WIDTH-1:0] period_reg,  period_next;
    logic             mode_reg,    mode_next;
    logic             timeout_reg, timeout_next;

    // Shadow value as seen this cycle: a Load coinciding with a Start or a
    // periodic wrap is used directly rather than one cycle late.
    logic [WIDTH-1:0] shadow_eff;
    logic [WIDTH-1:0] counter_inc;

    always_comb begin
        shadow_eff   = LoadWe ? LoadValue : shadow_reg;
        counter_inc  = counter_reg + WIDTH'(1);

        state_next   = state_reg;
        counter_next = counter_reg;
        shadow_next  = shadow_eff;
        period_next  = period_reg;
        mode_next    = mode_reg;
        timeout_next = 1'b0;

        if (Stop) begin
            state_next   = ST_IDLE;
            counter_next = '0;
        end else if (Start) begin
            state_next   = ST_RUN;
            counter_next = '0;
            mode_next    = Mode;
            period_next  = shadow_eff;
            // P=0 expires on the Start edge itself.
            timeout_next = Enable && (shadow_eff == '0);
        end else if ((state_reg == ST_RUN) && Enable) begin
            if (counter_reg < period_reg) begin
                counter_next = counter_inc;
                timeout_next = (counter_inc == period_reg);
            end else begin
                // Counter sits at the period for the pulse cycle; this edge
                // either retires the channel or starts the next period.
                counter_next = '0;
                if (mode_reg == MODE_PERIODIC) begin
                    period_next  = shadow_eff;
                    timeout_next = (shadow_eff == '0);
                end else begin
                    state_next = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!MR_n) begin
            state_reg   <= ST_IDLE;
            counter_reg <= '0;
            shadow_reg  <= RESET_PERIOD;
            period_reg  <= RESET_PERIOD;
            mode_reg    <= MODE_ONESHOT;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            shadow_reg  <= shadow_next;
            period_reg  <= period_next;
            mode_reg    <= mode_next;
            timeout_reg <= timeout_next;
        end
    end

    assign Timeout = timeout_reg;
    assign Busy    = (state_reg == ST_RUN);
    assign Count   = counter_reg;

endmodule

// File: rtl/delay_timer_bank.sv
// ----------------------------------------------------------------------------
// delay_timer_bank
//   Bank of NUM_CH independent programmable delay timers sharing one clock,
//   one reset, a global Enable and a single Load port.
//
//   Ports
//     Clock      in   rising-edge clock
//     MR_n       in   synchronous active-low reset
//     Enable     in   global run; low freezes all running counters
//     Load       in   write LoadValue into channel LoadCh's shadow period
//     LoadCh     in   target channel; out-of-range indices are ignored
//     LoadValue  in   period value P
//     Start      in   per-channel start / restart
//     Stop       in   per-channel abort
//     Mode       in   per-channel mode (0 one-shot, 1 periodic)
//     Timeout    out  per-channel one-cycle expiry pulse
//     Busy       out  per-channel running flag
//     Count      out  packed counters, channel i at [i*WIDTH +: WIDTH]
// ----------------------------------------------------------------------------
module delay_timer_bank
    import delay_timer_bank_pkg::*;
#(
    parameter  int          NUM_CH         = 4,
    parameter  int          WIDTH          = 27,
    parameter  int unsigned DEFAULT_PERIOD = 3,
    localparam int          CH_BITS        = calc_ch_bits(NUM_CH)
) (
    input  logic                    Clock,
    input  logic                    MR_n,
    input  logic                    Enable,
    input  logic                    Load,
    input  logic [CH_BITS-1:0]      LoadCh,
    input  logic [WIDTH-1:0]        LoadValue,
    input  logic [NUM_CH-1:0]       Start,
    input  logic [NUM_CH-1:0]       Stop,
    input  logic [NUM_CH-1:0]       Mode,
    output logic [NUM_CH-1:0]       Timeout,
    output logic [NUM_CH-1:0]       Busy,
    output logic [NUM_CH*WIDTH-1:0] Count
);

    logic [NUM_CH-1:0] load_we;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            // An index with no matching channel produces no strobe at all.
            assign load_we[gi] = Load && (LoadCh == CH_BITS'(gi));

            delay_timer_channel #(
                .WIDTH          (WIDTH),
                .DEFAULT_PERIOD (DEFAULT_PERIOD)
            ) u_channel (
                .Clock     (Clock),
                .MR_n      (MR_n),
                .Enable    (Enable),
                .LoadWe    (load_we[gi]),
                .LoadValue (LoadValue),
                .Start     (Start[gi]),
                .Stop      (Stop[gi]),
                .Mode      (Mode[gi]),
                .Timeout   (Timeout[gi]),
                .Busy      (Busy[gi]),
                .Count     (Count[gi*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule

// File: tb/tb_delay_timer_bank.sv
// ----------------------------------------------------------------------------
// tb_delay_timer_bank
//   Directed bench for delay_timer_bank. Three channels are used so that a
//   LoadCh value of 3 is a genuine out-of-range index.
// ----------------------------------------------------------------------------
module tb_delay_timer_bank;

    localparam int NUM_CH = 3;
    localparam int WIDTH  = 27;
    localparam int CH_BITS = 2;

    logic                    Clock;
    logic                    MR_n;
    logic                    Enable;
    logic                    Load;
    logic [CH_BITS-1:0]      LoadCh;
    logic [WIDTH-1:0]        LoadValue;
    logic [NUM_CH-1:0]       Start;
    logic [NUM_CH-1:0]       Stop;
    logic [NUM_CH-1:0]       Mode;
    logic [NUM_CH-1:0]       Timeout;
    logic [NUM_CH-1:0]       Busy;
    logic [NUM_CH*WIDTH-1:0] Count;

    int checks   = 0;
    int failures = 0;

    delay_timer_bank #(
        .NUM_CH         (NUM_CH),
        .WIDTH          (WIDTH),
        .DEFAULT_PERIOD (3)
    ) dut (
        .Clock     (Clock),
        .MR_n      (MR_n),
        .Enable    (Enable),
        .Load      (Load),
        .LoadCh    (LoadCh),
        .LoadValue (LoadValue),
        .Start     (Start),
        .Stop      (Stop),
        .Mode      (Mode),
        .Timeout   (Timeout),
        .Busy      (Busy),
        .Count     (Count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] cnt(input int ch);
        return Count[ch*WIDTH +: WIDTH];
    endfunction

    task automatic do_load(input logic [CH_BITS-1:0] ch, input logic [WIDTH-1:0] val);
        Load = 1'b1; LoadCh = ch; LoadValue = val;
        tick();
        Load = 1'b0;
    endtask

    initial begin
        MR_n = 1'b0; Enable = 1'b1; Load = 1'b0; LoadCh = '0; LoadValue = '0;
        Start = '0; Stop = '0; Mode = '0;

        // ---------------- reset defaults ----------------
        tick(); tick();
        MR_n = 1'b1;
        check("rst_timeout", Timeout, 0);
        check("rst_busy", Busy, 0);
        check("rst_count", Count, 0);

        // ---------------- one-shot ch0, default P=3 ----------------
        Start = 3'b001; Mode = 3'b000;
        tick();
        Start = '0;
        check("os_busy_k", Busy[0], 1);
        check("os_cnt_k", cnt(0), 0);
        check("os_to_k", Timeout[0], 0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("os_to_%0d", i), Timeout[0], (i == 3));
            check($sformatf("os_busy_%0d", i), Busy[0], (i < 4));
            check($sformatf("os_cnt_%0d", i), cnt(0), (i < 4) ? i : 0);
        end
        $display("step one-shot ch0 P=3 checks=%0d failures=%0d", checks, failures);

        // ---------------- periodic ch1 P=4, reload to P=1 mid-count -------
        do_load(2'd1, 27'd4);
        Start = 3'b010; Mode = 3'b010;
        tick();
        Start = '0;
        check("per_busy", Busy[1], 1);
        for (int t = 1; t <= 20; t++) begin
            if (t == 11) begin
                Load = 1'b1; LoadCh = 2'd1; LoadValue = 27'd1;
            end
            tick();
            Load = 1'b0;
            check($sformatf("per_to_%0d", t), Timeout[1],
                  (t == 4 || t == 9 || t == 14 || t == 16 || t == 18 || t == 20));
        end
        Stop = 3'b010;
        tick();
        Stop = '0;
        check("per_stop_busy", Busy[1], 0);
        check("per_stop_cnt", cnt(1), 0);
        check("per_stop_to", Timeout[1], 0);
        $display("step periodic ch1 4->1 checks=%0d failures=%0d", checks, failures);

        // ---------------- Enable pause on periodic ch1 P=10 ---------------
        do_load(2'd1, 27'd10);
        Start = 3'b010; Mode = 3'b010;
        tick();
        Start = '0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("en_cnt_pre_%0d", i), cnt(1), i);
        end
        Enable = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("en_cnt_frozen_%0d", i), cnt(1), 4);
            check($sformatf("en_to_frozen_%0d", i), Timeout[1], 0);
        end
        Enable = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("en_cnt_post_%0d", i), cnt(1), 4 + i);
            check($sformatf("en_to_post_%0d", i), Timeout[1], (i == 6));
        end
        tick();
        check("en_wrap_cnt", cnt(1), 0);
        check("en_wrap_to", Timeout[1], 0);
        check("en_wrap_busy", Busy[1], 1);
        Stop = 3'b010;
        tick();
        Stop = '0;
        $display("step enable pause ch1 P=10 checks=%0d failures=%0d", checks, failures);

        // ---------------- Start+Stop, restart on ch2 ----------------------
        Start = 3'b100; Stop = 3'b100;
        tick();
        Start = '0; Stop = '0;
        check("ss_busy", Busy[2], 0);
        check("ss_cnt", cnt(2), 0);
        do_load(2'd2, 27'd8);
        Start = 3'b100; Mode = 3'b000;
        tick();
        Start = '0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("rs_to_pre_%0d", i), Timeout[2], 0);
        end
        check("rs_cnt_pre", cnt(2), 5);
        Start = 3'b100;
        tick();
        Start = '0;
        check("rs_cnt_r", cnt(2), 0);
        check("rs_busy_r", Busy[2], 1);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("rs_to_%0d", i), Timeout[2], (i == 8));
            check($sformatf("rs_busy_%0d", i), Busy[2], (i < 9));
        end
        $display("step start/stop restart ch2 P=8 checks=%0d failures=%0d", checks, failures);

        // ---------------- bypass load P=0 periodic, out-of-range load -----
        Load = 1'b1; LoadCh = 2'd2; LoadValue = '0;
        Start = 3'b100; Mode = 3'b100;
        tick();
        Load = 1'b0; Start = '0;
        check("p0_to_k", Timeout[2], 1);
        check("p0_busy_k", Busy[2], 1);
        check("p0_cnt_k", cnt(2), 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("p0_to_%0d", i), Timeout[2], 1);
        end
        do_load(2'd3, 27'd77);
        check("oor_to2", Timeout[2], 1);
        Start = 3'b011; Mode = 3'b000;
        tick();
        Start = '0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            check($sformatf("oor_to0_%0d", i), Timeout[0], (i == 3));
            check($sformatf("oor_to1_%0d", i), Timeout[1], (i == 10));
            check($sformatf("oor_to2_%0d", i), Timeout[2], 1);
            check($sformatf("oor_busy0_%0d", i), Busy[0], (i < 4));
        end
        $display("step bypass P=0 and out-of-range load checks=%0d failures=%0d", checks, failures);

        // ---------------- reset mid-count on all channels -----------------
        Start = 3'b111; Mode = 3'b111;
        tick();
        Start = '0;
        tick(); tick();
        check("mr_busy_pre", Busy, 3'b111);
        MR_n = 1'b0; Start = 3'b001;
        tick();
        MR_n = 1'b1; Start = '0;
        check("mr_timeout", Timeout, 0);
        check("mr_busy", Busy, 0);
        check("mr_count", Count, 0);
        Start = 3'b111; Mode = 3'b000;
        tick();
        Start = '0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("mr_to_%0d", i), Timeout, (i == 3) ? 3'b111 : 3'b000);
            check($sformatf("mr_busy_%0d", i), Busy, (i < 4) ? 3'b111 : 3'b000);
        end
        $display("step reset mid-count checks=%0d failures=%0d", checks, failures);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/delay_timer_bank.md
# delay_timer_bank

Parametrised bank of independent programmable delay timers. Each channel counts clock cycles up to a run-time-loadable period and emits a one-cycle `Timeout` pulse, in one-shot or periodic mode. It generalises the fixed-divider delay loop to a run-time period, start/stop control, a global pause, and several channels. It sits next to the neural-network sequencers, which use it for settle delays, refresh ticks and watchdogs.

## Interface
- `NUM_CH`, 4, number of channels (≥1)
- `WIDTH`, 27, counter and period width in bits
- `DEFAULT_PERIOD`, 3, reset value of every channel's shadow and active period
- `CH_BITS`, derived, `$clog2(NUM_CH)` with a minimum of 1; not overridable
- `Clock`  input  1  sole clock; all logic on its rising edge
- `MR_n`  input  1  synchronous active-low reset, sampled on the `Clock` rising edge
- `Enable`  input  1  global run; low freezes all counters
- `Load`  input  1  write `LoadValue` into the shadow period of channel `LoadCh`
- `LoadCh`  input  CH_BITS  target channel for `Load`; writes with `LoadCh ≥ NUM_CH` are ignored
- `LoadValue`  input  WIDTH  period value P
- `Start`  input  NUM_CH  per-channel start/restart request
- `Stop`  input  NUM_CH  per-channel abort request
- `Mode`  input  NUM_CH  per-channel mode, sampled at Start: 0 one-shot, 1 periodic
- `Timeout`  output  NUM_CH  registered one-cycle pulse per expiry
- `Busy`  output  NUM_CH  registered; channel running
- `Count`  output  NUM_CH*WIDTH  current count; channel i occupies bits [i*WIDTH +: WIDTH]

## Operation
- Per-channel state:
  - shadow period (written by `Load`)
  - active period (copied from shadow at Start and at each periodic wrap)
  - counter
  - mode bit
  - FSM: IDLE, RUN
- Reset (`MR_n`=0 at an edge):
  - FSM=IDLE; counter=0
  - shadow period = active period = DEFAULT_PERIOD
  - `Timeout`=0, `Busy`=0
- IDLE:
  - `Start[i]` → RUN; counter=0; latch mode; active period = shadow period.
  - If `Load` targets the same channel in the same cycle, `LoadValue` is used directly (bypass).
- RUN, `Enable`=1:
  - If counter < active period, counter increments.
  - On the edge where the counter becomes equal to the active period, `Timeout[i]`=1 for exactly one cycle.
  - Counter == active period, one-shot: next edge → IDLE, counter=0.
  - Counter == active period, periodic: next edge → counter=0, active period reloaded from shadow, remains RUN.
- RUN, `Enable`=0:
  - Counter and FSM hold.
  - No new `Timeout` is generated; a pulse already asserted still drops after one cycle.
- Stop and Start:
  - `Stop[i]` in any state → IDLE, counter=0, `Timeout[i]`=0 next cycle.
  - `Start[i]` while RUN → restart: counter=0, mode and period re-latched.
  - `Start[i]` and `Stop[i]` in the same cycle: Stop wins.
- `Start`, `Stop` and `Load` act regardless of `Enable`.
- `Load` while RUN changes only the shadow period. It takes effect at the next Start or the next periodic wrap, never mid-count.
- Arithmetic:
  - Unsigned WIDTH-bit compare.
  - The counter never exceeds the active period, so there is no wrap past 2^WIDTH−1.
  - P = 2^WIDTH−1 is legal.

## Timing
- Start sampled at edge k, `Enable` held high:
  - `Timeout` is high during the cycle after edge k+P, i.e. latency P cycles.
  - Periodic pulses repeat every P+1 cycles.
- P=0:
  - One-shot: pulse asserted at edge k, IDLE at k+1.
  - Periodic: `Timeout` is continuously high.
- `Busy`:
  - Rises at Start edge k.
  - One-shot: falls at edge k+P+1.
  - Falls at the edge a Stop is sampled.
- Every `Enable`-low cycle while RUN adds exactly one cycle to the latency.
- Reset mid-count overrides everything. Outputs are at reset values after that edge, and a `Start` in a reset cycle is dropped.

## Structure
- Shared package/include:
  - `MODE_ONESHOT`=1'b0, `MODE_PERIODIC`=1'b1
  - FSM state encodings `ST_IDLE`, `ST_RUN`
- Sub-module `delay_timer_channel`:
  - One channel: counter, period registers, FSM, `Timeout`/`Busy` flops.
  - Instantiated NUM_CH times in a generate loop.
- Top level: decodes `Load`/`LoadCh` into per-channel write strobes and packs `Count`.

## Test plan
- Reset defaults, then one-shot `Start[0]` with P=3 → `Timeout[0]` high exactly one cycle, 3 cycles after the Start edge; `Busy[0]` low one cycle later; no further pulses.
- Periodic `Start[1]` with P=4 via `Load`, then `Load` P=1 mid-count → pulses at intervals 5,5 until the wrap after the Load, then intervals of 2.
- `Enable` low for 7 cycles mid-count on periodic P=10 → next pulse delayed by exactly 7 cycles; `Count[1]` frozen throughout.
- Same-cycle `Start[2]`+`Stop[2]` → stays IDLE; `Start` while RUN at count 5, P=8 → pulse 8 cycles after the restart.
- `Load` with `LoadCh`=2 and `Start[2]` in the same cycle, `LoadValue`=0, periodic → `Timeout[2]` stuck high; `Load` with `LoadCh`≥`NUM_CH` → no channel changes.
- `MR_n` low for one cycle during RUN on all channels → all `Timeout`/`Busy`/`Count` zero next cycle; periods back to 3.
